mac_tx_arbiter: RTL and testbench

Two-requester transmit scheduler between byte FIFOs and the `gig_eth_mac` TX interface, in the `clk_sel` (125 MHz) domain. It lets the traffic generator's TX FIFO and a second frame source, such as a control/reply FIFO, share the single MAC transmit port. It grants whole frames, using round-robin or fixed priority. It drives the MAC begin/ack/send handshake, enforces a programmable idle gap between frames, and flags FIFO underruns. It also counts frames sent per requester.

---
 rtl/eth_tx_pkg.sv | 20 ++
 rtl/tx_rr_select.sv | 33 +++
 rtl/mac_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_pkg
// Shared definitions for the MAC transmit scheduling path.
//   - tx_state_t      : encoding of the transmit arbiter state machine
//   - TX_IDLE..TX_GAP : state values
//   - REQ_GEN/REQ_CTL : requester indices (traffic generator / control FIFO)
// -----------------------------------------------------------------------------
package eth_tx_pkg;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_BEGIN = 2'd1;
    localparam tx_state_t TX_SEND  = 2'd2;
    localparam tx_state_t TX_GAP   = 2'd3;

    localparam logic REQ_GEN = 1'b0;
    localparam logic REQ_CTL = 1'b1;

endpackage

// File: rtl/tx_rr_select.sv
// -----------------------------------------------------------------------------
// tx_rr_select
// Combinational two-way frame selector.
// Ports:
//   empty[1:0]  in  : per-requester FIFO empty flags
//   last_grant  in  : requester that owned the previous frame
//   fixed_prio  in  : 1 = requester 0 always wins a tie, 0 = alternate
//   valid       out : at least one requester has data
//   sel         out : chosen requester index
// -----------------------------------------------------------------------------
module tx_rr_select
    import eth_tx_pkg::*;
(
    input  logic [1:0] empty,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = ~(empty[0] & empty[1]);
        sel   = REQ_GEN;
        if (!empty[0] && !empty[1]) begin
            // Tie: fixed priority favours the generator, otherwise hand the
            // port to whoever did not own the previous frame.
            sel = fixed_prio ? REQ_GEN : ~last_grant;
        end else if (!empty[1]) begin
            sel = REQ_CTL;
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter
// Whole-frame scheduler sharing the gig_eth_mac TX port between two
// first-word-fall-through byte FIFOs. Drives the MAC begin/ack/send handshake,
// holds an idle gap after each frame, flags mid-frame FIFO underruns and
// counts completed frames per requester.
// Ports:
//   clk_sel, rst                 : 125 MHz clock, async active-high reset
//   enable                       : gates new grants only
//   reqN_data/empty/last, reqN_read : FIFO dout, empty, almost_empty, rd_en
//   mac_tx_data/dvld/ack         : MAC transmit interface
//   mac_tx_underrun              : one-cycle pulse when the owner ran dry
//   grant, busy                  : current/last owner, state != IDLE
//   frames0, frames1             : completed frames per requester (wrapping)
// -----------------------------------------------------------------------------
module mac_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = 2,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk_sel,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  req0_data,
    input  logic        req0_empty,
    input  logic        req0_last,
    output logic        req0_read,
    input  logic [7:0]  req1_data,
    input  logic        req1_empty,
    input  logic        req1_last,
    output logic        req1_read,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_dvld,
    input  logic        mac_tx_ack,
    output logic        mac_tx_underrun,
    output logic        grant,
    output logic        busy,
    output logic [15:0] frames0,
    output logic [15:0] frames1
);

    // Final GAP count value; a zero gap still spends one cycle in GAP.
    localparam logic [8:0] IFG_LAST = (IFG_CYCLES == 0) ? 9'd0 : 9'(IFG_CYCLES - 1);

    tx_state_t   state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] frames0_q, frames0_d;
    logic [15:0] frames1_q, frames1_d;

    logic        sel_valid;
    logic        sel_idx;
    logic        own_empty;
    logic        own_last;
    logic        gap_done;
    logic        rd;

    tx_rr_select u_select (
        .empty      ({req1_empty, req0_empty}),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO),
        .valid      (sel_valid),
        .sel        (sel_idx)
    );

    assign own_empty = grant_q ? req1_empty : req0_empty;
    assign own_last  = grant_q ? req1_last  : req0_last;
    assign gap_done  = ({1'b0, gap_cnt_q} >= IFG_LAST);

    // State register
    always_ff @(posedge clk_sel or posedge rst) begin
        if (rst) begin
            state_q      <= TX_IDLE;
            grant_q      <= REQ_GEN;
            last_grant_q <= REQ_CTL;
            gap_cnt_q    <= 8'd0;
            frames0_q    <= 16'd0;
            frames1_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            frames0_q    <= frames0_d;
            frames1_q    <= frames1_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = 8'd0;
        frames0_d    = frames0_q;
        frames1_d    = frames1_q;
        case (state_q)
            TX_IDLE: begin
                if (enable && sel_valid) begin
                    grant_d = sel_idx;
                    state_d = TX_BEGIN;
                end
            end
            TX_BEGIN: begin
                if (mac_tx_ack) begin
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (own_last) begin
                    if (grant_q == REQ_GEN) begin
                        frames0_d = frames0_q + 16'd1;
                    end else begin
                        frames1_d = frames1_q + 16'd1;
                    end
                    last_grant_d = grant_q;
                    state_d      = TX_GAP;
                end else if (own_empty) begin
                    // Aborted frame still rotates ownership but is not counted.
                    last_grant_d = grant_q;
                    state_d      = TX_GAP;
                end
            end
            TX_GAP: begin
                if (gap_done) begin
                    state_d = TX_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs: purely combinational so the FIFO's fall-through byte reaches
    // the MAC in the same cycle it is read.
    always_comb begin
        rd              = 1'b0;
        mac_tx_underrun = 1'b0;
        case (state_q)
            TX_BEGIN: rd = mac_tx_ack;
            TX_SEND: begin
                if (!own_last && own_empty) begin
                    mac_tx_underrun = 1'b1;
                end else begin
                    rd = 1'b1;
                end
            end
            default: rd = 1'b0;
        endcase
        mac_tx_dvld = (state_q == TX_BEGIN) || (state_q == TX_SEND);
        busy        = (state_q != TX_IDLE);
        req0_read   = rd && (grant_q == REQ_GEN);
        req1_read   = rd && (grant_q == REQ_CTL);
        mac_tx_data = grant_q ? req1_data : req0_data;
    end

    assign grant   = grant_q;
    assign frames0 = frames0_q;
    assign frames1 = frames1_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
module tb_mac_tx_arbiter;

    typedef struct {
        bit         r;
        logic [7:0] d;
    } exp_t;

    logic clk_sel = 1'b0;
    always #5 clk_sel = ~clk_sel;

    logic rst, enable, use_fp, en_a, en_b;
    logic [7:0] req0_data, req1_data;
    logic req0_empty, req0_last, req1_empty, req1_last;
    logic mac_tx_ack;

    logic        a_rd0, a_rd1, a_dvld, a_und, a_grant, a_busy;
    logic [7:0]  a_data;
    logic [15:0] a_f0, a_f1;
    logic        b_rd0, b_rd1, b_dvld, b_und, b_grant, b_busy;
    logic [7:0]  b_data;
    logic [15:0] b_f0, b_f1;

    logic        rd0, rd1, mac_tx_dvld, mac_tx_underrun, grant, busy;
    logic [7:0]  mac_tx_data;
    logic [15:0] frames0, frames1;

    assign en_a = enable & ~use_fp;
    assign en_b = enable & use_fp;
    assign rd0             = use_fp ? b_rd0   : a_rd0;
    assign rd1             = use_fp ? b_rd1   : a_rd1;
    assign mac_tx_dvld     = use_fp ? b_dvld  : a_dvld;
    assign mac_tx_underrun = use_fp ? b_und   : a_und;
    assign grant           = use_fp ? b_grant : a_grant;
    assign busy            = use_fp ? b_busy  : a_busy;
    assign mac_tx_data     = use_fp ? b_data  : a_data;
    assign frames0         = use_fp ? b_f0    : a_f0;
    assign frames1         = use_fp ? b_f1    : a_f1;

    mac_tx_arbiter #(.IFG_CYCLES(2), .FIXED_PRIO(1'b0)) dut_a (
        .clk_sel(clk_sel), .rst(rst), .enable(en_a),
        .req0_data(req0_data), .req0_empty(req0_empty), .req0_last(req0_last), .req0_read(a_rd0),
        .req1_data(req1_data), .req1_empty(req1_empty), .req1_last(req1_last), .req1_read(a_rd1),
        .mac_tx_data(a_data), .mac_tx_dvld(a_dvld), .mac_tx_ack(mac_tx_ack),
        .mac_tx_underrun(a_und), .grant(a_grant), .busy(a_busy),
        .frames0(a_f0), .frames1(a_f1)
    );

    mac_tx_arbiter #(.IFG_CYCLES(2), .FIXED_PRIO(1'b1)) dut_b (
        .clk_sel(clk_sel), .rst(rst), .enable(en_b),
        .req0_data(req0_data), .req0_empty(req0_empty), .req0_last(req0_last), .req0_read(b_rd0),
        .req1_data(req1_data), .req1_empty(req1_empty), .req1_last(req1_last), .req1_read(b_rd1),
        .mac_tx_data(b_data), .mac_tx_dvld(b_dvld), .mac_tx_ack(mac_tx_ack),
        .mac_tx_underrun(b_und), .grant(b_grant), .busy(b_busy),
        .frames0(b_f0), .frames1(b_f1)
    );

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         l0[$];
    bit         l1[$];
    exp_t       expq[$];

    int checks = 0;
    int errors = 0;
    int ack_at = 1;
    int bytes_seen = 0;
    int starts = 0;
    int last_gap = 0;
    int und_pulses = 0;
    int und_max = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push_frame(input bit r, input int len, input logic [7:0] base, input bit with_last);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.r = r;
            e.d = base + 8'(i);
            if (r == 1'b0) begin
                q0.push_back(e.d);
                l0.push_back(with_last && (i == len - 1));
            end else begin
                q1.push_back(e.d);
                l1.push_back(with_last && (i == len - 1));
            end
            expq.push_back(e);
        end
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while ((expq.size() != 0 || busy) && n < maxc) begin
            @(negedge clk_sel);
            #3;
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d bytes outstanding, want 0", name, expq.size());
        end
    endtask

    task automatic wait_bytes(input int target, input int maxc, input string name);
        int n = 0;
        while (bytes_seen < target && n < maxc) begin
            @(negedge clk_sel);
            #3;
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, saw %0d bytes, want %0d", name, bytes_seen, target);
        end
    endtask

    // FIFO model: first-word-fall-through, popped on the edge that sees rd_en.
    initial begin
        logic p0, p1;
        req0_data = 8'h5A; req0_empty = 1'b1; req0_last = 1'b0;
        req1_data = 8'hA5; req1_empty = 1'b1; req1_last = 1'b0;
        forever begin
            @(posedge clk_sel);
            p0 = rd0;
            p1 = rd1;
            #1;
            if (p0 && q0.size() > 0) begin void'(q0.pop_front()); void'(l0.pop_front()); end
            if (p1 && q1.size() > 0) begin void'(q1.pop_front()); void'(l1.pop_front()); end
            req0_empty = (q0.size() == 0);
            req0_data  = req0_empty ? 8'h5A : q0[0];
            req0_last  = req0_empty ? 1'b0 : l0[0];
            req1_empty = (q1.size() == 0);
            req1_data  = req1_empty ? 8'hA5 : q1[0];
            req1_last  = req1_empty ? 1'b0 : l1[0];
        end
    end

    // MAC model: acknowledges in the ack_at-th BEGIN cycle.
    initial begin
        int  begin_cnt;
        bit  in_frame;
        mac_tx_ack = 1'b0;
        begin_cnt  = 0;
        in_frame   = 1'b0;
        forever begin
            @(negedge clk_sel);
            if (!mac_tx_dvld) begin
                in_frame   = 1'b0;
                begin_cnt  = 0;
                mac_tx_ack = 1'b0;
            end else if (mac_tx_ack) begin
                in_frame   = 1'b1;
                mac_tx_ack = 1'b0;
            end else if (!in_frame) begin
                begin_cnt++;
                if (begin_cnt >= ack_at) mac_tx_ack = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        bit   prev_dvld;
        int   idle_run;
        int   und_run;
        prev_dvld = 1'b0;
        idle_run  = 0;
        und_run   = 0;
        forever begin
            @(negedge clk_sel);
            #2;
            if (mac_tx_dvld && !prev_dvld) begin
                starts++;
                last_gap = idle_run;
            end
            if (!mac_tx_dvld) idle_run++;
            else idle_run = 0;
            prev_dvld = mac_tx_dvld;
            if (mac_tx_underrun) begin
                und_run++;
                if (und_run == 1) und_pulses++;
                if (und_run > und_max) und_max = und_run;
            end else begin
                und_run = 0;
            end
            if (mac_tx_dvld && (rd0 || rd1)) begin
                checks++;
                bytes_seen++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL byte: unexpected byte %02h from grant %0d, want none", mac_tx_data, grant);
                end else begin
                    e = expq.pop_front();
                    if (grant != e.r || mac_tx_data != e.d || (rd0 && rd1) || (e.r ? !rd1 : !rd0)) begin
                        errors++;
                        $display("FAIL byte: got grant %0d data %02h rd %0d%0d, want grant %0d data %02h",
                                 grant, mac_tx_data, rd1, rd0, e.r, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, f1, up, b0, s;
        rst    = 1'b1;
        enable = 1'b1;
        use_fp = 1'b0;
        repeat (3) @(negedge clk_sel);
        #3;
        chk("rst_dvld", int'(mac_tx_dvld), 0);
        chk("rst_read0", int'(rd0), 0);
        chk("rst_read1", int'(rd1), 0);
        chk("rst_underrun", int'(mac_tx_underrun), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_frames0", int'(frames0), 0);
        chk("rst_frames1", int'(frames1), 0);
        chk("rst_data", int'(mac_tx_data), 8'h5A);
        @(negedge clk_sel);
        rst = 1'b0;

        // Round-robin: 0,1,0,1,0,1
        @(negedge clk_sel);
        push_frame(1'b0, 4, 8'h10, 1'b1);
        push_frame(1'b1, 3, 8'h20, 1'b1);
        push_frame(1'b0, 5, 8'h30, 1'b1);
        push_frame(1'b1, 6, 8'h40, 1'b1);
        push_frame(1'b0, 3, 8'h50, 1'b1);
        push_frame(1'b1, 4, 8'h60, 1'b1);
        wait_idle(400, "rr_done");
        chk("rr_frames0", int'(frames0), 3);
        chk("rr_frames1", int'(frames1), 3);

        // Fixed priority: all requester-0 frames first
        @(negedge clk_sel);
        use_fp = 1'b1;
        push_frame(1'b0, 4, 8'h11, 1'b1);
        push_frame(1'b0, 3, 8'h21, 1'b1);
        push_frame(1'b0, 5, 8'h31, 1'b1);
        push_frame(1'b1, 3, 8'h41, 1'b1);
        push_frame(1'b1, 4, 8'h51, 1'b1);
        push_frame(1'b1, 2, 8'h61, 1'b1);
        wait_idle(400, "fp_done");
        chk("fp_frames0", int'(frames0), 3);
        chk("fp_frames1", int'(frames1), 3);
        @(negedge clk_sel);
        use_fp = 1'b0;

        // Single 64-byte frame, ack in 3rd BEGIN cycle, then a short frame
        ack_at = 3;
        f0 = int'(frames0);
        @(negedge clk_sel);
        push_frame(1'b0, 64, 8'h80, 1'b1);
        push_frame(1'b0, 4, 8'hC0, 1'b1);
        begin
            int n = 0;
            while (expq.size() > 4 && n < 500) begin
                @(negedge clk_sel);
                #3;
                n++;
            end
            if (n >= 500) begin
                checks++;
                errors++;
                $display("FAIL single_wait: timeout, %0d bytes outstanding, want 4", expq.size());
            end
        end
        @(negedge clk_sel);
        #3;
        chk("single_frames0", int'(frames0), f0 + 1);
        wait_idle(200, "single_done");
        chk("single_gap", last_gap, 3);
        chk("single_frames0_b", int'(frames0), f0 + 2);
        ack_at = 1;

        // Underrun on requester 1 after 10 bytes
        f1 = int'(frames1);
        up = und_pulses;
        @(negedge clk_sel);
        push_frame(1'b1, 10, 8'hE0, 1'b0);
        wait_idle(200, "und_done");
        repeat (2) @(negedge clk_sel);
        #3;
        chk("und_pulses", und_pulses, up + 1);
        chk("und_width", und_max, 1);
        chk("und_frames1", int'(frames1), f1);
        chk("und_busy", int'(busy), 0);

        // Enable gating
        f0 = int'(frames0);
        f1 = int'(frames1);
        b0 = bytes_seen;
        @(negedge clk_sel);
        push_frame(1'b0, 20, 8'h00, 1'b1);
        push_frame(1'b1, 5, 8'h70, 1'b1);
        wait_bytes(b0 + 5, 200, "en_start");
        @(negedge clk_sel);
        enable = 1'b0;
        s = starts;
        wait_bytes(b0 + 20, 200, "en_finish");
        repeat (12) @(negedge clk_sel);
        #3;
        chk("en_no_begin", starts, s);
        chk("en_busy", int'(busy), 0);
        chk("en_frames0", int'(frames0), f0 + 1);
        chk("en_pending", expq.size(), 5);
        enable = 1'b1;
        #1;
        chk("en_dvld_now", int'(mac_tx_dvld), 0);
        @(posedge clk_sel);
        @(posedge clk_sel);
        #1;
        chk("en_dvld_later", int'(mac_tx_dvld), 1);
        wait_idle(200, "en_done");
        chk("en_frames1", int'(frames1), f1 + 1);

        // Reset in the middle of SEND
        b0 = bytes_seen;
        @(negedge clk_sel);
        push_frame(1'b1, 30, 8'h90, 1'b1);
        wait_bytes(b0 + 5, 200, "rst_start");
        @(negedge clk_sel);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_dvld", int'(mac_tx_dvld), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_frames0", int'(frames0), 0);
        chk("midrst_frames1", int'(frames1), 0);
        q0.delete(); l0.delete();
        q1.delete(); l1.delete();
        expq.delete();
        repeat (2) @(posedge clk_sel);
        @(negedge clk_sel);
        rst = 1'b0;

        // Counter wrap
        @(negedge clk_sel);
        force dut_a.frames0_q = 16'hFFFF;
        #1;
        release dut_a.frames0_q;
        push_frame(1'b0, 3, 8'hA0, 1'b1);
        wait_idle(200, "wrap_done");
        chk("wrap_frames0", int'(frames0), 0);
        chk("wrap_frames1", int'(frames1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
